// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops 24-bit words and sends each as three 8N1 bytes, MSB byte first.
// Define PARITY_EN to add an even-parity bit after the data bits of every byte frame.
module fifo_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned GAP_BITS     = 1
) (
   input  logic        tx_spi_sclk_wire,
   input  logic        rst,
   input  logic        tx_enable,
   input  logic        fifo_empty,
   input  logic [23:0] fifo_q,
   output logic        fifo_rdreq,
   output logic        uart_txd,
   output logic [1:0]  uart_counter,
   output logic        idle,
   output logic [15:0] words_sent
);

   localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BitW  = (GAP_BITS > 8) ? $clog2(GAP_BITS) : 3;
   localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [BitW-1:0]  DataLast = BitW'(7);
   localparam logic [BitW-1:0]  GapLast  = BitW'((GAP_BITS == 0) ? 0 : GAP_BITS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StPop,
      StLatch,
      StStart,
      StData,
`ifdef PARITY_EN
      StParity,
`endif
      StStop,
      StGap
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_rdreq;
   logic              r_txd;
   logic [1:0]        r_counter;
   logic [15:0]       r_words;
   logic [BaudW-1:0]  r_baud;
   logic [BitW-1:0]   r_bit;
   logic [23:0]       r_word;
   logic [7:0]        r_byte;

   logic              w_tick;
   logic              w_timed;
   logic              w_txd_nxt;
   logic              w_pop;
   logic              w_latch;
   logic              w_next_byte;
   logic              w_word_done;

   assign w_tick  = (r_baud == BaudLast);
   assign w_timed = (r_state != StIdle) && (r_state != StPop) && (r_state != StLatch);

   always_ff @(posedge tx_spi_sclk_wire or negedge rst) begin
      if (!rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_txd_nxt   = 1'b1;
      w_pop       = 1'b0;
      w_latch     = 1'b0;
      w_next_byte = 1'b0;
      w_word_done = 1'b0;
      case (r_state)
         StIdle: begin
            if (tx_enable && !fifo_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = StPop;
            end
         end
         // fifo_q becomes valid the cycle after the pop strobe
         StPop: w_state_nxt = StLatch;
         StLatch: begin
            w_latch     = 1'b1;
            w_state_nxt = StStart;
         end
         StStart: begin
            w_txd_nxt = 1'b0;
            if (w_tick) w_state_nxt = StData;
         end
         StData: begin
            w_txd_nxt = r_byte[r_bit[2:0]];
            if (w_tick && (r_bit == DataLast)) begin
`ifdef PARITY_EN
               w_state_nxt = StParity;
`else
               w_state_nxt = StStop;
`endif
            end
         end
`ifdef PARITY_EN
         StParity: begin
            w_txd_nxt = ^r_byte;
            if (w_tick) w_state_nxt = StStop;
         end
`endif
         StStop: begin
            if (w_tick) begin
               if (r_counter != 2'd2) begin
                  w_next_byte = 1'b1;
                  w_state_nxt = StStart;
               end else begin
                  w_word_done = 1'b1;
                  w_state_nxt = (GAP_BITS == 0) ? StIdle : StGap;
               end
            end
         end
         StGap: begin
            if (w_tick && (r_bit == GapLast)) w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   // Line is driven from a register one cycle behind the state, so it never glitches.
   always_ff @(posedge tx_spi_sclk_wire or negedge rst) begin
      if (!rst) begin
         r_rdreq   <= 1'b0;
         r_txd     <= 1'b1;
         r_counter <= 2'd0;
         r_words   <= 16'd0;
         r_baud    <= '0;
         r_bit     <= '0;
         r_word    <= 24'd0;
         r_byte    <= 8'd0;
      end else begin
         r_rdreq <= w_pop;
         r_txd   <= w_txd_nxt;

         if (w_state_nxt != r_state) begin
            r_baud <= '0;
            r_bit  <= '0;
         end else if (w_timed) begin
            if (w_tick) begin
               r_baud <= '0;
               r_bit  <= r_bit + BitW'(1);
            end else begin
               r_baud <= r_baud + BaudW'(1);
            end
         end

         if (w_latch) begin
            r_word    <= fifo_q;
            r_byte    <= fifo_q[23:16];
            r_counter <= 2'd0;
         end else if (w_next_byte) begin
            r_counter <= r_counter + 2'd1;
            r_byte    <= (r_counter == 2'd0) ? r_word[15:8] : r_word[7:0];
         end else if ((w_state_nxt == StIdle) && (r_state != StIdle)) begin
            r_counter <= 2'd0;
         end

         if (w_word_done) r_words <= r_words + 16'd1;
      end
   end

   assign fifo_rdreq   = r_rdreq;
   assign uart_txd     = r_txd;
   assign uart_counter = r_counter;
   assign idle         = (r_state == StIdle);
   assign words_sent   = r_words;

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Read-side consumer of the measurement FIFO. Pops 24-bit words from the FIFO and serialises each word as three 8N1 UART bytes, MSB byte first, LSB bit first within a byte. Exports the idle flag and the 2-bit byte index so the FIFO-side controller can gate its own read/write timing. Sits between the measurement FIFO output and the board UART TX pin.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit period (minimum 2)
GAP_BITS, 1, idle-high bit periods inserted after each 3-byte word (0 allowed)

Ports:
tx_spi_sclk_wire  in   1   single clock; all logic on rising edge
rst               in   1   asynchronous, active-low reset
tx_enable         in   1   1 = new words may be started; sampled only in IDLE
fifo_empty        in   1   FIFO empty flag
fifo_q            in   24  FIFO read data, valid one cycle after fifo_rdreq
fifo_rdreq        out  1   single-cycle FIFO pop strobe
uart_txd          out  1   serial line, idle high
uart_counter      out  2   index of the byte currently on the line (0,1,2)
idle              out  1   1 when the FSM is in IDLE
words_sent        out  16  count of completed words, wraps at 0xFFFF->0

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, uart_txd=1, fifo_rdreq=0, uart_counter=0, idle=1, words_sent=0, shift/bit/baud counters=0, word register=0.
- States: IDLE, POP, LATCH, START, DATA, STOP, GAP.
- IDLE: if tx_enable && !fifo_empty -> fifo_rdreq=1 for exactly one cycle, go to POP. Otherwise stay; fifo_rdreq=0.
- POP: fifo_rdreq=0; wait one cycle (FIFO read latency 1) -> LATCH.
- LATCH: capture fifo_q into 24-bit word register; uart_counter=0; load byte = word[23:16] -> START.
- START: uart_txd=0 for CLKS_PER_BIT cycles -> DATA.
- DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles -> STOP.
- STOP: uart_txd=1 for CLKS_PER_BIT cycles. If uart_counter<2: increment uart_counter, load next byte (word[15:8], then word[7:0]) -> START. If uart_counter==2: words_sent+=1 -> GAP (or straight to IDLE if GAP_BITS=0).
- GAP: uart_txd=1 for GAP_BITS*CLKS_PER_BIT cycles -> IDLE; uart_counter returns to 0 on entering IDLE.
- idle=1 only in IDLE; it drops on the cycle fifo_rdreq asserts.
- Baud counter: counts 0..CLKS_PER_BIT-1; the bit advances on terminal count. Width is clog2(CLKS_PER_BIT).
- Latency: a word present in a non-empty FIFO puts its start bit on the line 3 cycles after the fifo_rdreq cycle.
- Full word: 30*CLKS_PER_BIT + GAP_BITS*CLKS_PER_BIT cycles from START until IDLE.
- tx_enable deassert mid-word: no effect; the word completes. It is checked only in IDLE.
- fifo_empty rising in POP/LATCH: ignored; the popped data is used.
- Never pops while not in IDLE. At most one rdreq per word.
- Reset mid-frame: the line returns high immediately, the partial word is discarded, and words_sent is cleared.
- uart_txd is registered (glitch-free).

Optional Feature:
PARITY_EN: when defined, each byte frame gets an even-parity bit between the 8th data bit and stop (state PARITY, CLKS_PER_BIT cycles, txd = XOR of the 8 data bits). A word then takes 33*CLKS_PER_BIT + gap cycles. When undefined, the frame is pure 8N1, the PARITY state does not exist, and the word takes 30*CLKS_PER_BIT + gap.

Test Plan:
- Reset: rst=0 mid-DATA with CLKS_PER_BIT=4 -> uart_txd=1, idle=1, fifo_rdreq=0, uart_counter=0, words_sent=0 within the same cycle (asynchronous).
- Single word: CLKS_PER_BIT=4, GAP_BITS=1, FIFO holds 0xA5C381, tx_enable=1 -> one rdreq pulse; line decodes bytes 0xA5, 0xC3, 0x81; uart_counter steps 0,1,2; words_sent=1; idle returns after 124 cycles from START.
- Back-to-back: FIFO holds 0x000001 and 0xFFFFFE -> exactly 2 rdreq pulses, each separated by ≥124 cycles; bytes 00 00 01 FF FF FE; words_sent=2.
- Empty/enable gating: fifo_empty=1, or tx_enable=0 with data present -> no rdreq and txd stays high for 500 cycles. Dropping tx_enable mid-word 0x123456 -> the word still completes and no further pop occurs.
- Wrap: preload words_sent=0xFFFF via a forced sequence, send one word -> words_sent=0x0000.
- PARITY_EN defined: word 0x030100 -> parity bits 0, 1, 0; word length 33*4+4=136 cycles.
